// File: rtl/imply_pkg.sv
// Shared types for the implication-stack arbiter.
// Holds the default variable width, the stack entry and the arbiter states.
package imply_pkg;

  localparam int IMPLY_VAR_BITS = 9;

  typedef struct packed {
    logic                      val;
    logic [IMPLY_VAR_BITS-1:0] vid;
  } imply_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    POP_CMD,
    POP_DATA,
    CLEAR
  } arb_state_e;

endpackage

// File: rtl/imply_stack_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid bit at or after the
// pointer, cyclically, as one-hot and index.
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_c;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_c      = '0;
    for (int k = 0; k < N; k++) begin
      w_c = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_valid[w_c]) begin
        o_any         = 1'b1;
        o_onehot[w_c] = 1'b1;
        o_idx         = w_c;
      end
    end
  end

endmodule

// File: rtl/imply_stack_arbiter.sv
// Push/pop sequencer for the BCP implication stack.
// Optional counters enabled by defining IMPLY_ARB_STATS_EN.
module imply_stack_arbiter
  import imply_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int VAR_BITS = IMPLY_VAR_BITS,
  parameter  int DEPTH    = 128,
  localparam int CNT_BITS = $clog2(DEPTH + 1),
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_val,
  input  logic [NUM_REQ*VAR_BITS-1:0] req_var,
  output logic [NUM_REQ-1:0]          req_grant,
  input  logic                        pop_req,
  output logic                        pop_ack,
  output logic                        pop_valid,
  output logic                        pop_val,
  output logic [VAR_BITS-1:0]         pop_var,
  input  logic                        flush,
  output logic                        conflict,
  output logic [VAR_BITS-1:0]         conflict_var,
  output logic [CNT_BITS-1:0]         count,
  output logic                        full,
  output logic                        empty,
  output logic                        stk_en,
  output logic                        stk_rw,
  output logic                        stk_clear,
  output logic                        stk_val,
  output logic [VAR_BITS-1:0]         stk_var,
  input  logic                        stk_val_in,
  input  logic [VAR_BITS-1:0]         stk_var_in
`ifdef IMPLY_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_pushes,
  output logic [31:0]                 stat_merges,
  output logic [15:0]                 stat_conflicts,
  output logic [31:0]                 stat_stall_cycles
`endif
);

  arb_state_e          r_state, w_next;
  logic [IW-1:0]       r_rr;
  logic [CNT_BITS-1:0] r_count;
  logic [VAR_BITS-1:0] r_cvar;
  logic                r_conflict;
  logic                r_stk_en, r_stk_rw, r_stk_clear, r_stk_val;
  logic [VAR_BITS-1:0] r_stk_var;
  logic                r_pop_valid;

  logic [VAR_BITS-1:0] w_var [NUM_REQ];
  logic                w_conf;
  logic [VAR_BITS-1:0] w_conf_var;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [IW-1:0]       w_win_idx;
  logic                w_any;
  logic                w_win_val;
  logic [VAR_BITS-1:0] w_win_var;
  logic                w_full, w_empty;
  logic                w_do_flush, w_do_conf, w_do_pop, w_do_push;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IW-1:0]       w_rr_next;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_var[i] = req_var[i*VAR_BITS +: VAR_BITS];
  end

  // Lowest i, then lowest j, wins among contradicting pairs
  always_comb begin
    w_conf     = 1'b0;
    w_conf_var = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (!w_conf && req_valid[i] && req_valid[j] &&
            w_var[i] == w_var[j] && req_val[i] != req_val[j]) begin
          w_conf     = 1'b1;
          w_conf_var = w_var[i];
        end
      end
    end
  end

  rr_picker #(.N(NUM_REQ)) u_pick (
    .i_valid  (req_valid),
    .i_ptr    (r_rr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_any)
  );

  assign w_win_val = req_val[w_win_idx];
  assign w_win_var = w_var[w_win_idx];
  assign w_full    = (r_count == CNT_BITS'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_rr_next = IW'((int'(w_win_idx) + 1) % NUM_REQ);

  always_comb begin
    w_next     = r_state;
    w_do_flush = 1'b0;
    w_do_conf  = 1'b0;
    w_do_pop   = 1'b0;
    w_do_push  = 1'b0;
    if (flush) begin
      w_do_flush = 1'b1;
      w_next     = CLEAR;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_conf) begin
            w_do_conf = 1'b1;
          end else if (pop_req && !w_empty) begin
            w_do_pop = 1'b1;
            w_next   = POP_CMD;
          end else if (w_any && !w_full) begin
            w_do_push = 1'b1;
          end
        end
        POP_CMD:  w_next = POP_DATA;
        POP_DATA: w_next = IDLE;
        CLEAR:    w_next = IDLE;
        default:  w_next = IDLE;
      endcase
    end
  end

  // Identical {var,val} requests ride along with the winner
  always_comb begin
    w_grant = '0;
    if (w_do_push) begin
      w_grant = w_win_oh;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && w_var[i] == w_win_var &&
            req_val[i] == w_win_val)
          w_grant[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_count     <= '0;
      r_cvar      <= '0;
      r_conflict  <= 1'b0;
      r_stk_en    <= 1'b0;
      r_stk_rw    <= 1'b0;
      r_stk_clear <= 1'b0;
      r_stk_val   <= 1'b0;
      r_stk_var   <= '0;
      r_pop_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_stk_en    <= 1'b0;
      r_stk_rw    <= 1'b0;
      r_stk_clear <= 1'b0;
      r_conflict  <= 1'b0;
      r_pop_valid <= 1'b0;
      if (w_do_flush) begin
        r_stk_en    <= 1'b1;
        r_stk_clear <= 1'b1;
        r_count     <= '0;
      end
      if (w_do_conf) begin
        r_conflict <= 1'b1;
        r_cvar     <= w_conf_var;
      end
      if (w_do_pop) begin
        r_stk_en <= 1'b1;
        r_count  <= r_count - CNT_BITS'(1);
      end
      if (w_do_push) begin
        r_stk_en  <= 1'b1;
        r_stk_rw  <= 1'b1;
        r_stk_val <= w_win_val;
        r_stk_var <= w_win_var;
        r_count   <= r_count + CNT_BITS'(1);
        r_rr      <= w_rr_next;
      end
      if (!flush && r_state == POP_CMD)
        r_pop_valid <= 1'b1;
    end
  end

  assign req_grant    = reset ? '0 : w_grant;
  assign pop_ack      = w_do_pop & ~reset;
  // A flush landing on the data cycle still kills the pop
  assign pop_valid    = r_pop_valid & ~flush;
  assign pop_val      = stk_val_in;
  assign pop_var      = stk_var_in;
  assign conflict     = r_conflict;
  assign conflict_var = r_cvar;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign stk_en       = r_stk_en;
  assign stk_rw       = r_stk_rw;
  assign stk_clear    = r_stk_clear;
  assign stk_val      = r_stk_val;
  assign stk_var      = r_stk_var;

`ifdef IMPLY_ARB_STATS_EN
  logic [31:0] r_pushes, r_merges, r_stalls;
  logic [15:0] r_confs;
  logic [31:0] w_ngrant;
  logic [32:0] w_msum;

  always_comb begin
    w_ngrant = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_ngrant = w_ngrant + 32'(w_grant[i]);
    w_msum = {1'b0, r_merges};
    if (w_do_push)
      w_msum = {1'b0, r_merges} + 33'(w_ngrant - 32'd1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pushes <= '0;
      r_merges <= '0;
      r_stalls <= '0;
      r_confs  <= '0;
    end else begin
      if (w_do_push && !(&r_pushes))
        r_pushes <= r_pushes + 32'd1;
      r_merges <= w_msum[32] ? '1 : w_msum[31:0];
      if (w_do_conf && !(&r_confs))
        r_confs <= r_confs + 16'd1;
      if (|req_valid && !(|w_grant) && !(&r_stalls))
        r_stalls <= r_stalls + 32'd1;
    end
  end

  assign stat_pushes       = r_pushes;
  assign stat_merges       = r_merges;
  assign stat_conflicts    = r_confs;
  assign stat_stall_cycles = r_stalls;
`endif

endmodule

// File: tb/tb_imply_stack_arbiter.sv
// Self-checking bench for imply_stack_arbiter: directed steps, then a
// random phase, against a queue-based model and a LIFO stack harness.
module tb_imply_stack_arbiter;
  import imply_pkg::*;

  localparam int N     = 4;
  localparam int VB    = 9;
  localparam int DEPTH = 128;
  localparam int CB    = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_val, req_grant;
  logic [N*VB-1:0] req_var;
  logic            pop_req, pop_ack, pop_valid, pop_val;
  logic [VB-1:0]   pop_var;
  logic            flush, conflict;
  logic [VB-1:0]   conflict_var;
  logic [CB-1:0]   count;
  logic            full, empty;
  logic            stk_en, stk_rw, stk_clear, stk_val;
  logic [VB-1:0]   stk_var;
  logic            stk_val_in = 1'b0;
  logic [VB-1:0]   stk_var_in = '0;
`ifdef IMPLY_ARB_STATS_EN
  logic [31:0] stat_pushes, stat_merges, stat_stall_cycles;
  logic [15:0] stat_conflicts;
`endif

  always #5 clock = ~clock;

  imply_stack_arbiter #(.NUM_REQ(N), .VAR_BITS(VB), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_val      (req_val),
    .req_var      (req_var),
    .req_grant    (req_grant),
    .pop_req      (pop_req),
    .pop_ack      (pop_ack),
    .pop_valid    (pop_valid),
    .pop_val      (pop_val),
    .pop_var      (pop_var),
    .flush        (flush),
    .conflict     (conflict),
    .conflict_var (conflict_var),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .stk_en       (stk_en),
    .stk_rw       (stk_rw),
    .stk_clear    (stk_clear),
    .stk_val      (stk_val),
    .stk_var      (stk_var),
    .stk_val_in   (stk_val_in),
    .stk_var_in   (stk_var_in)
`ifdef IMPLY_ARB_STATS_EN
    ,
    .stat_pushes       (stat_pushes),
    .stat_merges       (stat_merges),
    .stat_conflicts    (stat_conflicts),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  // Stand-in for imply_stack: LIFO with registered outputs
  imply_entry_t hq[$];
  imply_entry_t h_e;
  always @(posedge clock) begin
    if (stk_en) begin
      if (stk_clear) hq.delete();
      else if (stk_rw) hq.push_back('{val: stk_val, vid: stk_var});
      else if (hq.size() > 0) begin
        h_e = hq.pop_back();
        stk_val_in <= h_e.val;
        stk_var_in <= h_e.vid;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy, round-robin pointer, contents, phase
  int           m_cnt, m_rr, m_ph;
  imply_entry_t mq[$];
  imply_entry_t m_pop;
  logic [VB-1:0] m_cvar;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VB-1:0] rv(input int i);
    return req_var[i*VB +: VB];
  endfunction

  task automatic set_req(input int i, input bit v, input bit b,
                         input int id);
    req_valid[i] = v;
    req_val[i]   = b;
    req_var[i*VB +: VB] = VB'(id);
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_val   = '0;
    req_var   = '0;
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_rr   = 0;
    m_ph   = 0;
    m_cvar = '0;
    mq.delete();
  endtask

  // One clock: predict from the current inputs, check both sides of it
  task automatic tick();
    logic [N-1:0] eg;
    logic eack, epv, e_en, e_rw, e_clr, e_conf;
    imply_entry_t e_ent;
    int nph, w, c;
    bit found;
    eg = '0; eack = 0; e_en = 0; e_rw = 0; e_clr = 0; e_conf = 0;
    e_ent = '0; w = -1; found = 0;
    epv = (m_ph == 2) && !flush;
    nph = m_ph;
    if (flush) begin
      e_en = 1; e_clr = 1; m_cnt = 0; mq.delete(); nph = 3;
    end else if (m_ph == 0) begin
      for (int i = 0; i < N; i++)
        for (int j = i + 1; j < N; j++)
          if (!found && req_valid[i] && req_valid[j] &&
              rv(i) == rv(j) && req_val[i] != req_val[j]) begin
            found = 1;
            m_cvar = rv(i);
          end
      if (found) begin
        e_conf = 1;
      end else if (pop_req && m_cnt > 0) begin
        eack = 1; e_en = 1; m_cnt--; m_pop = mq.pop_back(); nph = 1;
      end else if (req_valid != '0 && m_cnt < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (w < 0 && req_valid[c]) w = c;
        end
        e_ent = '{val: req_val[w], vid: rv(w)};
        for (int i = 0; i < N; i++)
          if (req_valid[i] && req_val[i] == e_ent.val && rv(i) == e_ent.vid)
            eg[i] = 1'b1;
        mq.push_back(e_ent);
        m_cnt++;
        m_rr = (w + 1) % N;
        e_en = 1; e_rw = 1;
      end
    end else begin
      nph = (m_ph == 1) ? 2 : 0;
    end
    @(negedge clock);
    chk("req_grant", 32'(req_grant), 32'(eg));
    chk("pop_ack", 32'(pop_ack), 32'(eack));
    chk("pop_valid", 32'(pop_valid), 32'(epv));
    if (epv) chk("pop_data", {pop_val, pop_var}, {m_pop.val, m_pop.vid});
    @(posedge clock);
    #1;
    m_ph = nph;
    chk("stk_en", 32'(stk_en), 32'(e_en));
    chk("stk_clear", 32'(stk_clear), 32'(e_clr));
    if (e_en) chk("stk_rw", 32'(stk_rw), 32'(e_rw));
    if (e_rw) chk("stk_data", {stk_val, stk_var}, {e_ent.val, e_ent.vid});
    chk("count", 32'(count), 32'(m_cnt));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("conflict", 32'(conflict), 32'(e_conf));
    chk("conflict_var", 32'(conflict_var), 32'(m_cvar));
  endtask

  initial begin
    reset = 1'b1;
    pop_req = 1'b0;
    flush = 1'b0;
    clr_req();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_stk_en", 32'(stk_en), 0);
    chk("rst_conflict_var", 32'(conflict_var), 0);
    chk("rst_pop_valid", 32'(pop_valid), 0);
    reset = 1'b0;

    // reset while a push command is on the stack pins
    set_req(0, 1, 1, 42);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_stk_en", 32'(stk_en), 0);
    chk("midrst_stk_rw", 32'(stk_rw), 0);
    chk("midrst_stk_var", 32'(stk_var), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_grant", 32'(req_grant), 0);
    model_reset();
    clr_req();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // round robin over 1011: 0,1,3,0
    set_req(0, 1, 0, 10);
    set_req(1, 1, 1, 20);
    set_req(3, 1, 0, 30);
    repeat (4) tick();
    clr_req();

    // merge then conflict
    set_req(0, 1, 1, 5);
    set_req(2, 1, 1, 5);
    tick();
    clr_req();
    set_req(1, 1, 0, 7);
    set_req(3, 1, 1, 7);
    tick();
    chk("conflict_var_7", 32'(conflict_var), 7);
    clr_req();
    tick();

    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // LIFO pops with two-cycle latency
    set_req(0, 1, 1, 12);
    tick();
    set_req(0, 1, 0, 3);
    tick();
    clr_req();
    for (int p = 0; p < 2; p++) begin
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      tick();
      tick();
    end
    chk("empty_after_pops", 32'(empty), 1);

    // fill to capacity, then pop makes room for one push
    for (int i = 0; i < DEPTH; i++) begin
      set_req(0, 1, i[0], i);
      tick();
    end
    chk("full_at_depth", 32'(full), 1);
    set_req(0, 1, 1, 200);
    set_req(2, 1, 0, 201);
    repeat (3) tick();
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    repeat (4) tick();
    chk("full_refilled", 32'(full), 1);
    clr_req();

    // flush during POP_CMD
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_req(1, 1, 1, 77);
    tick();
    set_req(1, 1, 0, 78);
    tick();
    clr_req();
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_popcmd_clear", 32'(stk_clear), 1);
    flush = 1'b0;
    tick();
    tick();

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)));
      pop_req = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 30) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
